// File: rtl/dmem_store_buffer.sv
// Data-memory front end: posted-store FIFO plus one outstanding load over a handshaked memory port.
// Define SB_FWD_EN to let loads forward from buffered stores; otherwise loads wait for the buffer to drain.
module dmem_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_din,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  output logic              core_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  sb_count,
  output logic              sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, HIT, LREQ, LWAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              empty_q;
  logic              drain_pend;   // LREQ must first finish a drain that was stalled at load accept
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] rdata_q;

  logic              accepting, full, push, pop, load_acc, load_block;
  logic              drain_req, load_req, hit;
  logic [DATA_W-1:0] hit_data;

  // Cycles in which the core sees no stall and may present a new request.
  assign accepting = (state == IDLE) || (state == HIT) || (state == LWAIT && mem_rvalid);
  assign full      = (count == CNT_W'(DEPTH));

`ifdef SB_FWD_EN
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    // Scan oldest to youngest so the youngest match overrides.
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count && addr_q[head + PTR_W'(i)] == core_addr) begin
        hit      = 1'b1;
        hit_data = data_q[head + PTR_W'(i)];
      end
    end
  end
  assign load_block = 1'b0;
`else
  assign hit        = 1'b0;
  assign hit_data   = '0;
  assign load_block = (count != '0);
`endif

  assign core_stall = !accepting
                   || (core_req &&  core_we && full)
                   || (core_req && !core_we && load_block);
  assign push      = core_req &&  core_we && !core_stall;
  assign load_acc  = core_req && !core_we && !core_stall;

  assign drain_req = (state == IDLE && count != '0) || (state == LREQ && drain_pend);
  assign load_req  = (state == LREQ) && !drain_pend;
  assign pop       = drain_req && mem_ready;

  assign mem_req  = drain_req || load_req;
  assign mem_we   = drain_req;
  assign mem_addr = drain_req ? addr_q[head] : (load_req ? load_addr : '0);
  assign mem_din  = drain_req ? data_q[head] : '0;

  assign core_rvalid = (state == HIT) || (state == LWAIT && mem_rvalid);
  assign core_rdata  = (state == LWAIT && mem_rvalid) ? mem_rdata : rdata_q;

  assign sb_count = count;
  assign sb_empty = empty_q;

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: the entry storage has no reset; entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= core_addr;
      data_q[tail] <= core_din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      empty_q    <= 1'b1;
      drain_pend <= 1'b0;
      load_addr  <= '0;
      rdata_q    <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);

      if (state == LWAIT && mem_rvalid) rdata_q <= mem_rdata;

      if (load_acc) begin
        if (hit) begin
          rdata_q <= hit_data;
          state   <= HIT;
        end else begin
          load_addr  <= core_addr;
          drain_pend <= drain_req && !mem_ready;
          state      <= LREQ;
        end
      end else begin
        unique case (state)
          IDLE: state <= IDLE;
          HIT:  state <= IDLE;
          LREQ: begin
            if (mem_ready) begin
              if (drain_pend) drain_pend <= 1'b0;
              else            state      <= LWAIT;
            end
          end
          LWAIT: if (mem_rvalid) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: expected memory transactions and load data are queued
// by the stimulus and consumed by a monitor; a small responder returns read data.
module tb_dmem_store_buffer;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_din, core_rdata;
  logic        core_rvalid, core_stall;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_din, mem_rdata;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd[$];
  mem_t        exp_mem[$];
  logic [31:0] rd_val = 32'h0;
  int          rd_lat = 1;

  dmem_store_buffer dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_din(core_din),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid), .core_stall(core_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
    exp_mem.push_back('{1'b1, a, d});
  endtask

  task automatic exp_r(input logic [31:0] a);
    exp_mem.push_back('{1'b0, a, 32'h0});
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    core_req = 1'b1; core_we = 1'b1; core_addr = a; core_din = d;
  endtask

  task automatic load(input logic [31:0] a);
    core_req = 1'b1; core_we = 1'b0; core_addr = a; core_din = 32'h0;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    @(negedge clk);
    while (core_stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, core_stall, 1'b0);
    cyc();
  endtask

  task automatic wait_rvalid(input string name);
    int n = 0;
    @(negedge clk);
    while (!core_rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, core_rvalid, 1'b1);
    cyc();
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    @(negedge clk);
    while (!sb_empty && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, sb_empty, 1'b1);
    cyc();
  endtask

  // Monitor: every load completion and every accepted memory request must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (core_rvalid) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got load completion with data %0h, expected none", core_rdata);
        end else begin
          logic [31:0] e;
          e = exp_rd.pop_front();
          check("core_rdata", core_rdata, e);
        end
      end
      if (mem_req && mem_ready) begin
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: got we=%0d addr=%0h, expected no transaction", mem_we, mem_addr);
        end else begin
          mem_t m;
          m = exp_mem.pop_front();
          check("mem_we", mem_we, m.we);
          check("mem_addr", mem_addr, m.addr);
          if (m.we) check("mem_din", mem_din, m.din);
        end
      end
    end
  end

  // Read responder: returns rd_val rd_lat cycles after the read is accepted.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req && !mem_we && mem_ready) begin
        cyc();
        repeat (rd_lat - 1) cyc();
        mem_rvalid = 1'b1;
        mem_rdata  = rd_val;
        cyc();
        mem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_din = '0; mem_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rvalid", core_rvalid, 1'b0);
    check("rst_stall", core_stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_count", sb_count, 3'd0);
    check("rst_empty", sb_empty, 1'b1);
    check("rst_rdata", core_rdata, 32'h0);
    cyc();

    // Fill the buffer with memory held off, then stall a fifth store.
    for (int k = 0; k < 5; k++) exp_w(32'h100 + 32'(4 * k), 32'(k + 1));
    for (int k = 0; k < 4; k++) begin
      store(32'h100 + 32'(4 * k), 32'(k + 1));
      @(negedge clk);
      check("fill_stall", core_stall, 1'b0);
      cyc();
    end
    store(32'h110, 32'd5);
    @(negedge clk);
    check("full_count", sb_count, 3'd4);
    check("full_stall", core_stall, 1'b1);
    check("hold_addr0", mem_addr, 32'h100);
    check("hold_din0", mem_din, 32'd1);
    cyc();
    mem_ready = 1'b1;
    @(negedge clk);
    check("full_pop_stall", core_stall, 1'b1);
    check("full_pop_addr", mem_addr, 32'h100);
    cyc();
    @(negedge clk);
    check("after_pop_stall", core_stall, 1'b0);
    check("after_pop_count", sb_count, 3'd3);
    cyc();
    core_req = 1'b0;
    wait_empty("fill_drain");
    mem_ready = 1'b0;

    // Two stores to one address, then a load of it.
    exp_w(32'h200, 32'hAA);
    exp_w(32'h200, 32'hBB);
    exp_rd.push_back(32'hBB);
    store(32'h200, 32'hAA); cyc();
    store(32'h200, 32'hBB); cyc();
    load(32'h200);
`ifdef SB_FWD_EN
    @(negedge clk);
    check("fwd_accept", core_stall, 1'b0);
    cyc();
    core_req = 1'b0;
    @(negedge clk);
    check("fwd_rvalid", core_rvalid, 1'b1);
    check("fwd_no_memreq", mem_req, 1'b0);
    cyc();
    @(negedge clk);
    check("fwd_count", sb_count, 3'd2);
    cyc();
    mem_ready = 1'b1;
    wait_empty("fwd_drain");
`else
    exp_r(32'h200);
    rd_val = 32'hBB; rd_lat = 1;
    @(negedge clk);
    check("nofwd_stall", core_stall, 1'b1);
    cyc();
    mem_ready = 1'b1;
    wait_accept("nofwd_accept");
    core_req = 1'b0;
    wait_rvalid("nofwd_rvalid");
`endif
    mem_ready = 1'b0;
    cyc();

    // Miss load against an empty buffer, 3-cycle read latency.
    exp_r(32'h300);
    exp_rd.push_back(32'h1234);
    rd_val = 32'h1234; rd_lat = 3;
    mem_ready = 1'b1;
    load(32'h300);
    @(negedge clk);
    check("miss_accept", core_stall, 1'b0);
    cyc();
    core_req = 1'b0;
    @(negedge clk);
    check("miss_lreq_we", mem_we, 1'b0);
    check("miss_lreq_addr", mem_addr, 32'h300);
    check("miss_lreq_stall", core_stall, 1'b1);
    cyc();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("miss_wait_stall", core_stall, 1'b1);
      check("miss_wait_rvalid", core_rvalid, 1'b0);
      check("miss_wait_memreq", mem_req, 1'b0);
      cyc();
    end
    @(negedge clk);
    check("miss_rvalid", core_rvalid, 1'b1);
    check("miss_rv_stall", core_stall, 1'b0);
    cyc();
    @(negedge clk);
    check("miss_rdata_hold", core_rdata, 32'h1234);
    check("miss_rvalid_low", core_rvalid, 1'b0);
    cyc();
    mem_ready = 1'b0;

    // Load presented while a drain is held by mem_ready=0.
    rd_val = 32'h77; rd_lat = 2;
    exp_rd.push_back(32'h77);
    exp_w(32'h500, 32'h11);
`ifdef SB_FWD_EN
    exp_r(32'h600);
    exp_w(32'h504, 32'h22);
`else
    exp_w(32'h504, 32'h22);
    exp_r(32'h600);
`endif
    store(32'h500, 32'h11); cyc();
    store(32'h504, 32'h22); cyc();
    load(32'h600);
`ifdef SB_FWD_EN
    @(negedge clk);
    check("held_accept", core_stall, 1'b0);
    check("held_addr_a", mem_addr, 32'h500);
    cyc();
    core_req = 1'b0;
    @(negedge clk);
    check("held_we_b", mem_we, 1'b1);
    check("held_addr_b", mem_addr, 32'h500);
    check("held_din_b", mem_din, 32'h11);
    check("held_stall_b", core_stall, 1'b1);
    cyc();
    mem_ready = 1'b1;
    @(negedge clk);
    check("held_we_c", mem_we, 1'b1);
    check("held_addr_c", mem_addr, 32'h500);
    cyc();
    @(negedge clk);
    check("held_load_we", mem_we, 1'b0);
    check("held_load_addr", mem_addr, 32'h600);
    cyc();
    @(negedge clk);
    check("lwait_no_drain", mem_req, 1'b0);
    check("lwait_count", sb_count, 3'd1);
    check("lwait_stall", core_stall, 1'b1);
    cyc();
    wait_rvalid("held_rvalid");
    wait_empty("held_drain");
`else
    @(negedge clk);
    check("held_stall_a", core_stall, 1'b1);
    check("held_addr_a", mem_addr, 32'h500);
    check("held_din_a", mem_din, 32'h11);
    cyc();
    @(negedge clk);
    check("held_addr_b", mem_addr, 32'h500);
    check("held_din_b", mem_din, 32'h11);
    cyc();
    mem_ready = 1'b1;
    wait_accept("held_accept");
    core_req = 1'b0;
    wait_rvalid("held_rvalid");
`endif
    mem_ready = 1'b0;
    cyc();

    // Reset with stores buffered and a read outstanding; the late read data must be ignored.
    rd_val = 32'hDEAD; rd_lat = 4;
    exp_w(32'h700, 32'h31);
`ifndef SB_FWD_EN
    exp_w(32'h704, 32'h32);
    exp_w(32'h708, 32'h33);
`endif
    exp_r(32'h800);
    store(32'h700, 32'h31); cyc();
    store(32'h704, 32'h32); cyc();
    store(32'h708, 32'h33); cyc();
    load(32'h800);
    mem_ready = 1'b1;
    wait_accept("rst_ld_accept");
    core_req = 1'b0;
    @(negedge clk);
    check("rst_ld_lreq", mem_req && !mem_we, 1'b1);
    cyc();
    mem_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_count", sb_count, 3'd0);
    check("midrst_empty", sb_empty, 1'b1);
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_rvalid", core_rvalid, 1'b0);
    check("midrst_stall", core_stall, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      check("late_rvalid", core_rvalid, 1'b0);
      check("late_mem_req", mem_req, 1'b0);
    end
    cyc();

    // Pointer wrap: ten store/drain pairs with memory always ready.
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_w(32'h1000 + 32'(4 * k), 32'h5000 + 32'(k));
      store(32'h1000 + 32'(4 * k), 32'h5000 + 32'(k));
      @(negedge clk);
      check("wrap_stall", core_stall, 1'b0);
      cyc();
      core_req = 1'b0;
      @(negedge clk);
      check("wrap_count1", sb_count, 3'd1);
      cyc();
      @(negedge clk);
      check("wrap_count0", sb_count, 3'd0);
      cyc();
    end
    mem_ready = 1'b0;

    repeat (5) cyc();
    check("exp_mem_left", 64'(exp_mem.size()), 64'd0);
    check("exp_rd_left", 64'(exp_rd.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
